// File: rtl/mem_stage.sv
// Memory stage of the five-stage core: one outstanding data-memory access,
// load/store lane alignment, and stall generation toward execute.
package mem_stage_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef struct packed {
        logic       is_load;
        logic       is_store;
        logic [1:0] size;
        logic       is_unsigned;
    } mem_ctrl_t;

    typedef struct packed {
        logic       we;
        logic [4:0] rd;
    } rf_ctrl_t;

endpackage

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int N_BITS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vld_in,
    input  logic [N_BITS-1:0] alu_result_in,
    input  logic [N_BITS-1:0] store_data_in,
    input  mem_ctrl_t         mem_ctrl_pkt_in,
    input  rf_ctrl_t          rf_ctrl_pkt_in,
    output rf_ctrl_t          rf_ctrl_pkt_out,
    output logic [N_BITS-1:0] data_out,
    output logic              vld,
    input  logic              stall_in,
    output logic              stall,
    input  logic              squash_in,
    output logic              squash,
    output logic              dmem_req_vld,
    input  logic              dmem_req_rdy,
    output logic              dmem_req_we,
    output logic [N_BITS-1:0] dmem_req_addr,
    output logic [3:0]        dmem_req_be,
    output logic [N_BITS-1:0] dmem_req_wdata,
    input  logic              dmem_rsp_vld,
    input  logic [N_BITS-1:0] dmem_rsp_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_RSP = 2'd1,
        ST_DONE     = 2'd2,
        ST_DRAIN    = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              vld_r;
    logic [31:0]       alu_r;
    logic [31:0]       store_data_r;
    mem_ctrl_t         ctrl_r;
    rf_ctrl_t          rf_r;
    logic [31:0]       rdata_buf_r;

    logic              mem_op_s;
    logic              req_vld_s;
    logic              op_done_s;
    logic              buf_load_s;
    logic              gen_stall_s;
    logic              stall_s;
    logic [31:0]       load_data_s;
    logic [31:0]       data_s;

    function automatic logic [31:0] align_load(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  size,
                                               input logic        uns);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res_v;
        byte_v = word[{lane, 3'b000} +: 8];
        half_v = word[{lane[1], 4'b0000} +: 16];
        case (size)
            SIZE_B:  res_v = uns ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
            SIZE_H:  res_v = uns ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
            default: res_v = word;
        endcase
        return res_v;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] lane,
                                            input logic [1:0] size);
        logic [3:0] be_v;
        case (size)
            SIZE_B:  be_v = 4'b0001 << lane;
            SIZE_H:  be_v = lane[1] ? 4'b1100 : 4'b0011;
            default: be_v = 4'b1111;
        endcase
        return be_v;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [31:0] sd,
                                                input logic [1:0]  size);
        logic [31:0] wd_v;
        case (size)
            SIZE_B:  wd_v = {4{sd[7:0]}};
            SIZE_H:  wd_v = {2{sd[15:0]}};
            default: wd_v = sd;
        endcase
        return wd_v;
    endfunction

    assign mem_op_s    = vld_r & (ctrl_r.is_load | ctrl_r.is_store);
    assign gen_stall_s = mem_op_s & ~squash_in & ~op_done_s;
    assign stall_s     = stall_in | gen_stall_s;
    assign load_data_s = align_load(dmem_rsp_rdata, alu_r[1:0], ctrl_r.size, ctrl_r.is_unsigned);

    // Valid bit from execute; a squash kills it even while the stage is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= 1'b0;
        end else if (squash_in) begin
            vld_r <= 1'b0;
        end else if (!stall_s) begin
            vld_r <= vld_in;
        end
    end

    // Execute-to-memory payload registers, held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_r        <= 32'd0;
            store_data_r <= 32'd0;
            ctrl_r       <= '0;
            rf_r         <= '0;
        end else if (!stall_s) begin
            alu_r        <= alu_result_in;
            store_data_r <= store_data_in;
            ctrl_r       <= mem_ctrl_pkt_in;
            rf_r         <= rf_ctrl_pkt_in;
        end
    end

    // Access-tracking state and the buffer holding load data across a downstream stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rdata_buf_r <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            if (buf_load_s) begin
                rdata_buf_r <= load_data_s;
            end
        end
    end

    // Next state, request issue and completion of the current memory op.
    always_comb begin
        state_nxt_s = state_r;
        req_vld_s   = 1'b0;
        op_done_s   = 1'b0;
        buf_load_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                req_vld_s = mem_op_s & ~squash_in;
                if (req_vld_s && dmem_req_rdy) begin
                    if (ctrl_r.is_load) begin
                        state_nxt_s = ST_WAIT_RSP;
                    end else begin
                        op_done_s   = 1'b1;
                        state_nxt_s = stall_in ? ST_DONE : ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_RSP: begin
                if (squash_in) begin
                    state_nxt_s = ST_DRAIN;
                end else if (dmem_rsp_vld) begin
                    op_done_s   = 1'b1;
                    buf_load_s  = stall_in;
                    state_nxt_s = stall_in ? ST_DONE : ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_RSP;
                end
            end
            ST_DONE: begin
                op_done_s = 1'b1;
                if (!stall_in || squash_in) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_DRAIN: begin
                // The squashed load's response is swallowed here; nothing new issues until it lands.
                if (dmem_rsp_vld) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Result toward writeback: buffered load, live load response, or ALU result.
    always_comb begin
        data_s = alu_r;
        if (ctrl_r.is_load && state_r == ST_DONE) begin
            data_s = rdata_buf_r;
        end else if (ctrl_r.is_load && state_r == ST_WAIT_RSP) begin
            data_s = load_data_s;
        end else begin
            data_s = alu_r;
        end
    end

    assign data_out        = data_s;
    assign rf_ctrl_pkt_out = rf_r;
    assign vld             = vld_r & ~squash_in & ~gen_stall_s;
    assign stall           = stall_s;
    assign squash          = squash_in;
    assign dmem_req_vld    = req_vld_s;
    assign dmem_req_we     = ctrl_r.is_store & ~ctrl_r.is_load;
    assign dmem_req_addr   = {alu_r[31:2], 2'b00};
    assign dmem_req_be     = store_be(alu_r[1:0], ctrl_r.size);
    assign dmem_req_wdata  = store_wdata(store_data_r, ctrl_r.size);

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected writeback results,
// a negedge monitor compares them whenever the stage presents vld.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld_in;
    logic [31:0] alu_result_in;
    logic [31:0] store_data_in;
    mem_ctrl_t   mem_ctrl_pkt_in;
    rf_ctrl_t    rf_ctrl_pkt_in;
    rf_ctrl_t    rf_ctrl_pkt_out;
    logic [31:0] data_out;
    logic        vld;
    logic        stall_in;
    logic        stall;
    logic        squash_in;
    logic        squash;
    logic        dmem_req_vld;
    logic        dmem_req_rdy;
    logic        dmem_req_we;
    logic [31:0] dmem_req_addr;
    logic [3:0]  dmem_req_be;
    logic [31:0] dmem_req_wdata;
    logic        dmem_rsp_vld;
    logic [31:0] dmem_rsp_rdata;

    typedef struct packed {
        logic [31:0] data;
        rf_ctrl_t    rf;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_stage #(.N_BITS(32)) dut (
        .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .alu_result_in(alu_result_in),
        .store_data_in(store_data_in), .mem_ctrl_pkt_in(mem_ctrl_pkt_in),
        .rf_ctrl_pkt_in(rf_ctrl_pkt_in), .rf_ctrl_pkt_out(rf_ctrl_pkt_out),
        .data_out(data_out), .vld(vld), .stall_in(stall_in), .stall(stall),
        .squash_in(squash_in), .squash(squash), .dmem_req_vld(dmem_req_vld),
        .dmem_req_rdy(dmem_req_rdy), .dmem_req_we(dmem_req_we),
        .dmem_req_addr(dmem_req_addr), .dmem_req_be(dmem_req_be),
        .dmem_req_wdata(dmem_req_wdata), .dmem_rsp_vld(dmem_rsp_vld),
        .dmem_rsp_rdata(dmem_rsp_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    function automatic mem_ctrl_t mk(input logic ld, input logic st, input logic [1:0] sz, input logic u);
        return mem_ctrl_t'{is_load: ld, is_store: st, size: sz, is_unsigned: u};
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Writeback monitor: compare every presented result against the scoreboard head.
    always @(negedge clk) begin
        if (vld !== 1'b0) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_vld: got vld=%b data_out=%h, expected no result", vld, data_out);
            end else begin
                chk("wb_data", data_out, exp_q[0].data);
                chk("wb_rf", {26'd0, rf_ctrl_pkt_out}, {26'd0, exp_q[0].rf});
                if (stall_in == 1'b0) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic load_op(input logic [31:0] addr, input logic [1:0] sz, input logic u,
                           input logic [31:0] rdata, input logic [31:0] expd,
                           input int dly, input rf_ctrl_t rf);
        int stalls = 0;
        vld_in = 1'b1; alu_result_in = addr; store_data_in = 32'h5A5A_5A5A;
        mem_ctrl_pkt_in = mk(1'b1, 1'b0, sz, u); rf_ctrl_pkt_in = rf;
        exp_q.push_back(exp_t'{data: expd, rf: rf});
        nxt();
        vld_in = 1'b0; dmem_req_rdy = 1'b1;
        mid();
        chk1("ld_req_vld", dmem_req_vld, 1'b1);
        chk("ld_req_addr", dmem_req_addr, {addr[31:2], 2'b00});
        chk1("ld_req_we", dmem_req_we, 1'b0);
        if (stall === 1'b1) stalls++;
        nxt();
        dmem_req_rdy = 1'b0;
        for (int i = 1; i < dly; i++) begin
            mid();
            chk1("ld_no_second_req", dmem_req_vld, 1'b0);
            if (stall === 1'b1) stalls++;
            nxt();
        end
        dmem_rsp_vld = 1'b1; dmem_rsp_rdata = rdata;
        mid();
        chk1("ld_vld", vld, 1'b1);
        chk1("ld_stall_release", stall, 1'b0);
        chk("ld_stall_cycles", stalls, dly);
        nxt();
        dmem_rsp_vld = 1'b0; dmem_rsp_rdata = 32'd0;
    endtask

    task automatic store_op(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] sd,
                            input logic [31:0] e_addr, input logic [3:0] e_be,
                            input logic [31:0] e_wdata, input int rdy_dly, input rf_ctrl_t rf);
        int stalls = 0;
        vld_in = 1'b1; alu_result_in = addr; store_data_in = sd;
        mem_ctrl_pkt_in = mk(1'b0, 1'b1, sz, 1'b0); rf_ctrl_pkt_in = rf;
        exp_q.push_back(exp_t'{data: addr, rf: rf});
        nxt();
        vld_in = 1'b0;
        for (int i = 0; i <= rdy_dly; i++) begin
            dmem_req_rdy = (i == rdy_dly);
            mid();
            chk1("st_req_vld", dmem_req_vld, 1'b1);
            chk1("st_req_we", dmem_req_we, 1'b1);
            chk("st_req_addr", dmem_req_addr, e_addr);
            chk("st_req_be", {28'd0, dmem_req_be}, {28'd0, e_be});
            chk("st_req_wdata", dmem_req_wdata, e_wdata);
            if (i < rdy_dly) begin
                if (stall === 1'b1) stalls++;
                chk1("st_vld_early", vld, 1'b0);
            end else begin
                chk1("st_vld", vld, 1'b1);
                chk1("st_stall_release", stall, 1'b0);
            end
            nxt();
        end
        dmem_req_rdy = 1'b0;
        mid();
        chk1("st_req_drop", dmem_req_vld, 1'b0);
        chk("st_stall_cycles", stalls, rdy_dly);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded 100000 time units, required to finish earlier");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; vld_in = 1'b0; alu_result_in = 32'd0; store_data_in = 32'd0;
        mem_ctrl_pkt_in = '0; rf_ctrl_pkt_in = '0; stall_in = 1'b0; squash_in = 1'b0;
        dmem_req_rdy = 1'b0; dmem_rsp_vld = 1'b0; dmem_rsp_rdata = 32'd0;
        nxt();
        vld_in = 1'b1; alu_result_in = 32'hFFFF_FFFF; mem_ctrl_pkt_in = mk(1'b1, 1'b0, SIZE_W, 1'b0);
        rf_ctrl_pkt_in = rf_ctrl_t'{we: 1'b1, rd: 5'd31}; stall_in = 1'b1; squash_in = 1'b1;
        mid();
        chk1("rst_vld", vld, 1'b0);
        chk1("rst_req_vld", dmem_req_vld, 1'b0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_rf_out", {26'd0, rf_ctrl_pkt_out}, 32'd0);
        chk1("rst_stall_follow", stall, 1'b1);
        chk1("rst_squash_follow", squash, 1'b1);
        nxt();
        vld_in = 1'b0; stall_in = 1'b0; squash_in = 1'b0; rf_ctrl_pkt_in = '0; mem_ctrl_pkt_in = '0;
        rst_n = 1'b1;
        nxt();

        // Plain ALU op
        vld_in = 1'b1; alu_result_in = 32'h0000_1234; mem_ctrl_pkt_in = mk(1'b0, 1'b0, SIZE_W, 1'b0);
        rf_ctrl_pkt_in = rf_ctrl_t'{we: 1'b1, rd: 5'd3};
        exp_q.push_back(exp_t'{data: 32'h0000_1234, rf: rf_ctrl_t'{we: 1'b1, rd: 5'd3}});
        nxt();
        vld_in = 1'b0;
        mid();
        chk1("alu_vld", vld, 1'b1);
        chk1("alu_no_req", dmem_req_vld, 1'b0);
        nxt();
        mid();
        chk1("alu_vld_drop", vld, 1'b0);

        // Loads
        load_op(32'h0000_0103, SIZE_B, 1'b0, 32'h80FF_FFFF, 32'hFFFF_FF80, 2, rf_ctrl_t'{we: 1'b1, rd: 5'd4});
        load_op(32'h0000_0103, SIZE_B, 1'b1, 32'h80FF_FFFF, 32'h0000_0080, 2, rf_ctrl_t'{we: 1'b1, rd: 5'd5});
        load_op(32'h0000_0101, SIZE_B, 1'b0, 32'h0000_7F00, 32'h0000_007F, 1, rf_ctrl_t'{we: 1'b1, rd: 5'd6});
        load_op(32'h0000_0002, SIZE_H, 1'b0, 32'h8001_7FFF, 32'hFFFF_8001, 1, rf_ctrl_t'{we: 1'b1, rd: 5'd7});
        load_op(32'h0000_0003, SIZE_H, 1'b1, 32'h8001_7FFF, 32'h0000_8001, 1, rf_ctrl_t'{we: 1'b1, rd: 5'd8});
        load_op(32'h0000_0000, SIZE_H, 1'b0, 32'h1234_F00D, 32'hFFFF_F00D, 1, rf_ctrl_t'{we: 1'b1, rd: 5'd9});
        load_op(32'h0000_0007, SIZE_W, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 3, rf_ctrl_t'{we: 1'b1, rd: 5'd10});

        // Stores
        store_op(32'h0000_0202, SIZE_H, 32'hABCD_1234, 32'h0000_0200, 4'b1100, 32'h1234_1234, 3, rf_ctrl_t'{we: 1'b0, rd: 5'd11});
        store_op(32'h0000_0012, SIZE_B, 32'h0000_00A5, 32'h0000_0010, 4'b0100, 32'hA5A5_A5A5, 0, rf_ctrl_t'{we: 1'b0, rd: 5'd12});
        store_op(32'h0000_0021, SIZE_H, 32'h5555_BEEF, 32'h0000_0020, 4'b0011, 32'hBEEF_BEEF, 0, rf_ctrl_t'{we: 1'b0, rd: 5'd13});
        store_op(32'h0000_0033, SIZE_W, 32'h0123_4567, 32'h0000_0030, 4'b1111, 32'h0123_4567, 1, rf_ctrl_t'{we: 1'b0, rd: 5'd14});

        // LW response under downstream stall
        vld_in = 1'b1; alu_result_in = 32'h0000_0300; mem_ctrl_pkt_in = mk(1'b1, 1'b0, SIZE_W, 1'b0);
        rf_ctrl_pkt_in = rf_ctrl_t'{we: 1'b1, rd: 5'd15}; dmem_req_rdy = 1'b1;
        exp_q.push_back(exp_t'{data: 32'hDEAD_BEEF, rf: rf_ctrl_t'{we: 1'b1, rd: 5'd15}});
        nxt();
        vld_in = 1'b0;
        mid();
        chk1("done_req", dmem_req_vld, 1'b1);
        nxt();
        dmem_rsp_vld = 1'b1; dmem_rsp_rdata = 32'hDEAD_BEEF; stall_in = 1'b1;
        mid();
        chk1("done_rsp_vld", vld, 1'b1);
        chk1("done_stall", stall, 1'b1);
        nxt();
        dmem_rsp_vld = 1'b0; dmem_rsp_rdata = 32'd0;
        mid();
        chk1("done_hold_vld", vld, 1'b1);
        chk("done_buf_data", data_out, 32'hDEAD_BEEF);
        chk1("done_no_req", dmem_req_vld, 1'b0);
        nxt();
        stall_in = 1'b0;
        mid();
        chk1("done_release_vld", vld, 1'b1);
        chk1("done_release_no_req", dmem_req_vld, 1'b0);
        nxt();
        dmem_req_rdy = 1'b0;
        mid();
        chk1("done_after_vld", vld, 1'b0);

        // Squash during WAIT_RSP, then LW to 0x40 held until the drain
        vld_in = 1'b1; alu_result_in = 32'h0000_0500; mem_ctrl_pkt_in = mk(1'b1, 1'b0, SIZE_W, 1'b0);
        rf_ctrl_pkt_in = rf_ctrl_t'{we: 1'b1, rd: 5'd16}; dmem_req_rdy = 1'b1;
        nxt();
        vld_in = 1'b0;
        mid();
        chk1("sq_first_req", dmem_req_vld, 1'b1);
        nxt();
        squash_in = 1'b1;
        mid();
        chk1("sq_squash_out", squash, 1'b1);
        chk1("sq_no_req", dmem_req_vld, 1'b0);
        chk1("sq_no_vld", vld, 1'b0);
        nxt();
        squash_in = 1'b0; vld_in = 1'b1; alu_result_in = 32'h0000_0040;
        mem_ctrl_pkt_in = mk(1'b1, 1'b0, SIZE_W, 1'b0); rf_ctrl_pkt_in = rf_ctrl_t'{we: 1'b1, rd: 5'd17};
        exp_q.push_back(exp_t'{data: 32'h1122_3344, rf: rf_ctrl_t'{we: 1'b1, rd: 5'd17}});
        mid();
        chk1("sq_capture_stall", stall, 1'b0);
        nxt();
        vld_in = 1'b0;
        mid();
        chk1("sq_drain_withhold", dmem_req_vld, 1'b0);
        chk1("sq_drain_stall", stall, 1'b1);
        nxt();
        dmem_rsp_vld = 1'b1; dmem_rsp_rdata = 32'hBAD0_BAD0;
        mid();
        chk1("sq_drain_rsp_no_req", dmem_req_vld, 1'b0);
        chk1("sq_drain_rsp_no_vld", vld, 1'b0);
        nxt();
        dmem_rsp_vld = 1'b0; dmem_rsp_rdata = 32'd0;
        mid();
        chk1("sq_new_req", dmem_req_vld, 1'b1);
        chk("sq_new_addr", dmem_req_addr, 32'h0000_0040);
        nxt();
        dmem_req_rdy = 1'b0; dmem_rsp_vld = 1'b1; dmem_rsp_rdata = 32'h1122_3344;
        mid();
        chk1("sq_new_vld", vld, 1'b1);
        nxt();
        dmem_rsp_vld = 1'b0; dmem_rsp_rdata = 32'd0;

        // Reset while a load is outstanding
        vld_in = 1'b1; alu_result_in = 32'h0000_0600; mem_ctrl_pkt_in = mk(1'b1, 1'b0, SIZE_W, 1'b0);
        rf_ctrl_pkt_in = rf_ctrl_t'{we: 1'b1, rd: 5'd18}; dmem_req_rdy = 1'b1;
        nxt();
        vld_in = 1'b0;
        mid();
        chk1("rm_req", dmem_req_vld, 1'b1);
        nxt();
        dmem_req_rdy = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk1("rm_vld", vld, 1'b0);
        chk1("rm_req_vld", dmem_req_vld, 1'b0);
        chk("rm_data_out", data_out, 32'd0);
        chk("rm_rf_out", {26'd0, rf_ctrl_pkt_out}, 32'd0);
        chk1("rm_stall", stall, 1'b0);
        nxt();
        rst_n = 1'b1;
        nxt();
        dmem_rsp_vld = 1'b1; dmem_rsp_rdata = 32'h7777_7777;
        mid();
        chk1("rm_late_rsp_vld", vld, 1'b0);
        chk1("rm_late_rsp_req", dmem_req_vld, 1'b0);
        nxt();
        dmem_rsp_vld = 1'b0; dmem_rsp_rdata = 32'd0;
        mid();
        chk1("rm_idle_vld", vld, 1'b0);
        nxt();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage core. Sits directly downstream of the execute stage and upstream of writeback. Consumes the ALU result, store data, register-file control packet and valid bit. Issues at most one outstanding data-memory request over a valid/ready channel, aligns and extends load data, and forwards the result to writeback. Generates its own stall while a memory access is incomplete and passes stall/squash upstream.

## Interface
- `N_BITS`, default 32 — datapath width. Only 32 is supported.
- `clk` — input, 1 — clock.
- `rst_n` — input, 1 — reset; one clock; asynchronous, active-low.
- `vld_in` — input, 1 — execute-stage result is valid.
- `alu_result_in` — input, N_BITS — execute `data_out`; this is the address for memory ops.
- `store_data_in` — input, N_BITS — rs2 value for stores.
- `mem_ctrl_pkt_in` — input, `$bits(mem_ctrl_t)` — fields `{is_load, is_store, size[1:0] (0=B, 1=H, 2=W), is_unsigned}`.
- `rf_ctrl_pkt_in` / `rf_ctrl_pkt_out` — input / output, `$bits(rf_ctrl_t)` — writeback control; registered pass-through.
- `data_out` — output, N_BITS — result to writeback.
- `vld` — output, 1 — `data_out` and `rf_ctrl_pkt_out` are valid this cycle.
- `stall_in` / `stall` — input / output, 1 — downstream stall; `stall = stall_in | gen_stall`.
- `squash_in` / `squash` — input / output, 1 — `squash = squash_in`; this stage generates no squash.
- `dmem_req_vld` / `dmem_req_rdy` — output / input, 1 — request handshake.
- `dmem_req_we` — output, 1 — 1 = store.
- `dmem_req_addr` — output, N_BITS — `{addr[31:2], 2'b00}`.
- `dmem_req_be` — output, 4 — byte enables.
- `dmem_req_wdata` — output, N_BITS — lane-replicated store data.
- `dmem_rsp_vld` — input, 1 — load response valid. Stores get no response.
- `dmem_rsp_rdata` — input, N_BITS — load response word.

## Operation
- **Pipeline registers.** Registers for vld, alu_result, store_data, mem_ctrl_pkt and rf_ctrl_pkt are all enabled by `!stall` and reset to 0.
  - The vld register loads 0 whenever `squash_in` = 1, regardless of enable.
- **Memory op definition.** `mem_op = vld_q & (is_load | is_store)`.
- **FSM states.** IDLE, WAIT_RSP, DONE, DRAIN.
- **IDLE**
  - `dmem_req_vld = mem_op & !squash_in`.
  - Store accepted (`req_vld & req_rdy`): the op is complete. Go to DONE if `stall_in`, else stay in IDLE.
  - Load accepted: go to WAIT_RSP.
- **WAIT_RSP**
  - If `squash_in`: go to DRAIN.
  - Else if `rsp_vld & stall_in`: capture the aligned data into `rdata_buf` and go to DONE.
  - Else if `rsp_vld`: go to IDLE.
- **DONE**
  - No request is issued; `data_out` comes from `rdata_buf` for loads.
  - Go to IDLE when `!stall_in` or `squash_in`.
- **DRAIN**
  - The squashed load's response is discarded; go to IDLE on `rsp_vld`.
  - Pipeline registers advance normally.
  - A new `mem_op` present in DRAIN is not issued and raises `gen_stall` until the drain completes.
- **gen_stall.** Asserted when `mem_op & !squash_in` and the op is not complete this cycle. Complete means:
  - store accepted in IDLE;
  - `rsp_vld` in WAIT_RSP;
  - state is DONE.
- **Load data alignment** (lane = `addr[1:0]`)
  - B: byte `rdata[8*lane +: 8]`.
  - H: half `rdata[16*addr[1] +: 16]`; `addr[0]` is ignored.
  - W: `addr[1:0]` ignored.
  - Sign-extend unless `is_unsigned`.
- **Store data alignment**
  - B: `be = 4'b0001 << lane`, `wdata = {4{sd[7:0]}}`.
  - H: `be = 4'b0011 << 2*addr[1]`, `wdata = {2{sd[15:0]}}`.
  - W: `be = 4'b1111`, `wdata = sd`.
  - Misaligned accesses raise no exception.
- **data_out**
  - Non-load ops: `alu_result_q`.
  - Load completing in WAIT_RSP: the aligned `rsp_rdata`, combinationally.
  - DONE: `rdata_buf`.
- **vld** = `vld_q & !squash_in & !gen_stall`.

## Timing
- **Reset values.** Async reset forces:
  - state to IDLE;
  - all registers and `rdata_buf` to 0;
  - `vld` = 0, `dmem_req_vld` = 0, `data_out` = 0, `rf_ctrl_pkt_out` = 0.
  - `stall` and `squash` follow `stall_in` and `squash_in`.
- **Non-memory op.** 1 cycle: `vld` is asserted in the cycle after capture.
- **Store.**
  - Request is issued in the capture+1 cycle.
  - `vld` is asserted in the cycle `req_rdy` = 1; stall is released that same cycle.
- **Load.**
  - Request is issued in cycle C.
  - On accept in cycle A ≥ C, `rsp_vld` is legal no earlier than A+1.
  - `vld`/`data_out` appear in the response cycle.
- **Request stability.** `dmem_req_*` is held stable while `req_vld & !req_rdy`.
- **Outstanding limit.** One request at most; `req_vld` is never asserted in WAIT_RSP or DRAIN.
- **Reset mid-transaction.** Any response that arrives after reset is ignored, because state is IDLE.

## Test plan
- ALU op with `alu_result_in = 0x1234`, no memory op → `vld` = 1 and `data_out` = 0x1234 one cycle later; `dmem_req_vld` stays 0.
- LB at addr 0x103 with `rdata = 0x80FFFFFF`, `req_rdy` = 1 at once, `rsp` two cycles later → `be` n/a, `addr` = 0x100, `stall` = 1 for 2 cycles, `data_out` = 0xFFFFFF80. Repeat with LBU → 0x00000080.
- SH at 0x202 with `sd = 0xABCD1234`, `req_rdy` held low 3 cycles → `req` stable 4 cycles with `be` = 1100, `wdata` = 0x12341234; `stall` = 1 for 3 cycles; `vld` pulses in the accept cycle.
- LW response arrives with `stall_in` = 1 for 2 cycles → state DONE, `vld` held with `data_out` = `rdata_buf`, no second request; advances when `stall_in` drops.
- `squash_in` pulsed while in WAIT_RSP; the next op is LW to 0x40 → that LW's request is withheld until the old response is consumed, and the discarded data never shows on `data_out`.
- `rst_n` low during WAIT_RSP → outputs return to their reset values immediately; a late `rsp_vld` produces no `vld`.
